// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_e         : sequencer state (normal flow / MUL occupying EX)
//   mul_cnt_t       : width of the MUL occupancy down-counter
//   MUL_LAT_DEFAULT : default total EX-stage cycles for a MUL
//   REG_ADDR_W      : architectural register address width
package pipe_ctrl_pkg;

    localparam int unsigned MUL_LAT_DEFAULT = 4;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned MUL_CNT_W       = 4;

    typedef logic [MUL_CNT_W-1:0] mul_cnt_t;

    typedef enum logic {
        S_RUN,
        S_MUL
    } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Purely combinational.
//   mem_read_i   : instruction in EX is a load
//   ex_rt_i      : load destination register
//   id_rs_i      : rs of the instruction in ID (always a source)
//   id_rt_i      : rt of the instruction in ID
//   id_uses_rt_i : ID instruction reads rt as a source
//   load_use_o   : hazard present
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);

    // $zero is never a real dependency.
    assign load_use_o = mem_read_i && (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline (ID/EX region).
// Handles load-use bubbles, multi-cycle MUL occupancy of EX and taken-branch
// flush of IF/ID, and keeps saturating stall/flush cycle counters.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   ID_*_i             : source regs / rt usage / branch outcome of ID instr
//   EX_*_i             : load info and MUL start pulse of EX instr
//   PC_write_o ..      : combinational pipeline enables, bubbles and flush
//   mul_done_o         : MUL result valid in EX this cycle
//   stall_cycles_o     : registered count of stall cycles (saturating)
//   flush_cycles_o     : registered count of flush cycles (saturating)
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,  // legal range 2..16
    parameter int unsigned CNT_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] ID_RSaddr_i,
    input  logic [REG_ADDR_W-1:0] ID_RTaddr_i,
    input  logic                  ID_UsesRT_i,
    input  logic                  ID_BranchTaken_i,
    input  logic                  EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] EX_RTaddr_i,
    input  logic                  EX_MulStart_i,
    output logic                  PC_write_o,
    output logic                  IFID_write_o,
    output logic                  IFID_flush_o,
    output logic                  IDEX_write_o,
    output logic                  IDEX_bubble_o,
    output logic                  EXMEM_bubble_o,
    output logic                  mul_done_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_cycles_o
);

    // The start cycle and the done cycle are not counted by cnt, hence -2.
    localparam mul_cnt_t MulCntInit = mul_cnt_t'(MUL_LAT - 2);

    state_e           state_q;
    mul_cnt_t         cnt_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic load_use;
    logic mul_stall;
    logic mul_last;
    logic stall_event;

    load_use_detect u_load_use_detect (
        .mem_read_i   (EX_MemRead_i),
        .ex_rt_i      (EX_RTaddr_i),
        .id_rs_i      (ID_RSaddr_i),
        .id_rt_i      (ID_RTaddr_i),
        .id_uses_rt_i (ID_UsesRT_i),
        .load_use_o   (load_use)
    );

    assign mul_stall = ((state_q == S_RUN) && EX_MulStart_i) ||
                       ((state_q == S_MUL) && (cnt_q != '0));
    assign mul_last  = (state_q == S_MUL) && (cnt_q == '0);

    // Priority: reset > mul_stall > load_use > flush.
    always_comb begin
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IDEX_write_o   = 1'b1;
        IDEX_bubble_o  = 1'b0;
        EXMEM_bubble_o = 1'b0;
        IFID_flush_o   = 1'b0;
        mul_done_o     = 1'b0;
        if (rst_i) begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_write_o   = 1'b0;
            IDEX_bubble_o  = 1'b1;
            EXMEM_bubble_o = 1'b1;
        end else if (mul_stall) begin
            // Freeze the front end; EX/MEM receives bubbles while MUL holds EX.
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_write_o   = 1'b0;
            EXMEM_bubble_o = 1'b1;
        end else begin
            mul_done_o = mul_last;
            if (load_use) begin
                // ID/EX still clocks in, but with zeroed control.
                PC_write_o    = 1'b0;
                IFID_write_o  = 1'b0;
                IDEX_bubble_o = 1'b1;
            end else begin
                IFID_flush_o = ID_BranchTaken_i;
            end
        end
    end

    assign stall_event = !rst_i && (mul_stall || load_use);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (EX_MulStart_i) begin
                        state_q <= S_MUL;
                        cnt_q   <= MulCntInit;
                    end
                end
                S_MUL: begin
                    // A new MulStart here is ignored: EX is still occupied.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - mul_cnt_t'(1);
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                end
            endcase

            if (stall_event && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (IFID_flush_o && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_cycles_o = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. A second instance with a
// 4-bit counter width shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_branch, ex_mem_read, ex_mul_start;

    logic        pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_b, done;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_b, s_exmem_b, s_done;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [6:0]  outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // {PC_write, IFID_write, IDEX_write, IDEX_bubble, EXMEM_bubble, IFID_flush, mul_done}
    assign outs = {pc_w, ifid_w, idex_w, idex_b, exmem_b, ifid_f, done};

    localparam logic [6:0] O_RST  = 7'b000_1100;
    localparam logic [6:0] O_NORM = 7'b111_0000;
    localparam logic [6:0] O_LU   = 7'b001_1000;
    localparam logic [6:0] O_MUL  = 7'b000_0100;
    localparam logic [6:0] O_DONE = 7'b111_0001;
    localparam logic [6:0] O_FL   = 7'b111_0010;

    pipeline_hazard_controller #(.MUL_LAT(4), .CNT_W(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ID_RSaddr_i      (id_rs),
        .ID_RTaddr_i      (id_rt),
        .ID_UsesRT_i      (id_uses_rt),
        .ID_BranchTaken_i (id_branch),
        .EX_MemRead_i     (ex_mem_read),
        .EX_RTaddr_i      (ex_rt),
        .EX_MulStart_i    (ex_mul_start),
        .PC_write_o       (pc_w),
        .IFID_write_o     (ifid_w),
        .IFID_flush_o     (ifid_f),
        .IDEX_write_o     (idex_w),
        .IDEX_bubble_o    (idex_b),
        .EXMEM_bubble_o   (exmem_b),
        .mul_done_o       (done),
        .stall_cycles_o   (stall_cnt),
        .flush_cycles_o   (flush_cnt)
    );

    pipeline_hazard_controller #(.MUL_LAT(4), .CNT_W(4)) dut_sat (
        .clk_i            (clk),
        .rst_i            (rst),
        .ID_RSaddr_i      (id_rs),
        .ID_RTaddr_i      (id_rt),
        .ID_UsesRT_i      (id_uses_rt),
        .ID_BranchTaken_i (id_branch),
        .EX_MemRead_i     (ex_mem_read),
        .EX_RTaddr_i      (ex_rt),
        .EX_MulStart_i    (ex_mul_start),
        .PC_write_o       (s_pc_w),
        .IFID_write_o     (s_ifid_w),
        .IFID_flush_o     (s_ifid_f),
        .IDEX_write_o     (s_idex_w),
        .IDEX_bubble_o    (s_idex_b),
        .EXMEM_bubble_o   (s_exmem_b),
        .mul_done_o       (s_done),
        .stall_cycles_o   (s_stall_cnt),
        .flush_cycles_o   (s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_branch = 1'b0;
        ex_mem_read = 1'b0; ex_mul_start = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rt_ex, input logic [4:0] rs_id);
        ex_mem_read = 1'b1; ex_rt = rt_ex; id_rs = rs_id;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        ex_mul_start = 1'b1;

        // Reset held for two edges with a MUL start presented.
        tick(); settle();
        check("rst_outs_c1", 32'(outs), 32'(O_RST));
        tick(); settle();
        check("rst_outs_c2", 32'(outs), 32'(O_RST));
        rst = 1'b0; ex_mul_start = 1'b0;
        settle();
        check("post_rst_outs", 32'(outs), 32'(O_NORM));
        check("post_rst_stall", stall_cnt, 32'd0);
        check("post_rst_flush", flush_cnt, 32'd0);

        // Load-use on rs.
        set_load_use(5'd8, 5'd8);
        settle();
        check("lu_rs_outs", 32'(outs), 32'(O_LU));
        tick();
        idle_inputs();
        settle();
        check("lu_rs_after", 32'(outs), 32'(O_NORM));
        check("lu_rs_stall", stall_cnt, 32'd1);

        // Load into $zero is never a hazard.
        set_load_use(5'd0, 5'd0);
        settle();
        check("lu_zero_outs", 32'(outs), 32'(O_NORM));
        tick();
        check("lu_zero_stall", stall_cnt, 32'd1);

        // rt match only counts when ID reads rt.
        idle_inputs();
        set_load_use(5'd9, 5'd3);
        id_rt = 5'd9; id_uses_rt = 1'b0;
        settle();
        check("lu_rt_unused", 32'(outs), 32'(O_NORM));
        id_uses_rt = 1'b1;
        settle();
        check("lu_rt_used", 32'(outs), 32'(O_LU));
        tick();
        idle_inputs();
        settle();
        check("lu_rt_stall", stall_cnt, 32'd2);

        // MUL, MUL_LAT=4: stall T0..T2, done T3, normal T4.
        ex_mul_start = 1'b1;
        settle();
        check("mul_t0", 32'(outs), 32'(O_MUL));
        tick(); ex_mul_start = 1'b0; settle();
        check("mul_t1", 32'(outs), 32'(O_MUL));
        tick(); settle();
        check("mul_t2", 32'(outs), 32'(O_MUL));
        tick(); settle();
        check("mul_t3_done", 32'(outs), 32'(O_DONE));
        tick(); settle();
        check("mul_t4", 32'(outs), 32'(O_NORM));
        check("mul_stall_cnt", stall_cnt, 32'd5);

        // MUL start with coincident load-use and branch; second start ignored.
        ex_mul_start = 1'b1; id_branch = 1'b1;
        set_load_use(5'd8, 5'd8);
        settle();
        check("co_t0", 32'(outs), 32'(O_MUL));
        tick();
        ex_mem_read = 1'b0;  // ex_mul_start stays high: a second start
        settle();
        check("co_t1", 32'(outs), 32'(O_MUL));
        tick(); ex_mul_start = 1'b0; settle();
        check("co_t2", 32'(outs), 32'(O_MUL));
        tick(); settle();
        // Stall is over, so the waiting branch now flushes alongside done.
        check("co_t3", 32'(outs), 32'(O_DONE | O_FL));
        tick(); idle_inputs(); settle();
        check("co_t4", 32'(outs), 32'(O_NORM));
        check("co_stall_cnt", stall_cnt, 32'd8);
        check("co_flush_cnt", flush_cnt, 32'd1);

        // Branch with no hazard flushes; with load-use it does not.
        id_branch = 1'b1;
        settle();
        check("br_outs", 32'(outs), 32'(O_FL));
        tick();
        check("br_flush_cnt", flush_cnt, 32'd2);
        set_load_use(5'd8, 5'd8);
        settle();
        check("br_lu_outs", 32'(outs), 32'(O_LU));
        tick();
        idle_inputs();
        settle();
        check("br_lu_flush_cnt", flush_cnt, 32'd2);
        check("br_lu_stall_cnt", stall_cnt, 32'd9);

        // Reset in T1 of a MUL abandons it without a done pulse.
        ex_mul_start = 1'b1;
        settle();
        check("mr_t0", 32'(outs), 32'(O_MUL));
        tick(); ex_mul_start = 1'b0; rst = 1'b1; settle();
        check("mr_t1_rst", 32'(outs), 32'(O_RST));
        tick(); rst = 1'b0; settle();
        check("mr_t2", 32'(outs), 32'(O_NORM));
        check("mr_stall_cnt", stall_cnt, 32'd0);
        tick(); settle();
        check("mr_t3_no_done", 32'(outs), 32'(O_NORM));

        // 20 load-use cycles: 4-bit counter saturates at 15.
        set_load_use(5'd8, 5'd8);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        idle_inputs();
        settle();
        check("sat_stall_4b", 32'(s_stall_cnt), 32'd15);
        check("sat_stall_32b", stall_cnt, 32'd20);
        check("sat_flush_4b", 32'(s_flush_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline, sitting beside the forwarding logic in the ID/EX region.
- Handles three cases:
  - Load-use hazards, with a 1-cycle bubble.
  - Multi-cycle MUL occupancy of EX, via a counter FSM that freezes the front end.
  - Taken-branch flush of IF/ID.
- Maintains saturating performance counters for stall and flush cycles.

Parameters:
- MUL_LAT, 4: total EX-stage cycles for a MUL; legal range 2..16.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- ID_RSaddr_i  in  5  rs of the instruction in ID
- ID_RTaddr_i  in  5  rt of the instruction in ID
- ID_UsesRT_i  in  1  ID instruction reads rt as a source
- ID_BranchTaken_i  in  1  branch resolved taken in ID
- EX_MemRead_i  in  1  instruction in EX is a load
- EX_RTaddr_i  in  5  load destination register in EX
- EX_MulStart_i  in  1  MUL entered EX this cycle (1-cycle pulse)
- PC_write_o  out  1  PC update enable
- IFID_write_o  out  1  IF/ID register enable
- IFID_flush_o  out  1  zero IF/ID on the next edge
- IDEX_write_o  out  1  ID/EX register enable
- IDEX_bubble_o  out  1  load zeroed control into ID/EX
- EXMEM_bubble_o  out  1  load zeroed control into EX/MEM
- mul_done_o  out  1  MUL result valid in EX this cycle
- stall_cycles_o  out  CNT_W  count of stall cycles
- flush_cycles_o  out  CNT_W  count of flush cycles

Behaviour:
- **States.** S_RUN and S_MUL, plus a down-counter cnt (4 bits).
- **Reset** (rst_i=1 at the edge):
  - state<=S_RUN, cnt<=0, both counters<=0.
  - While rst_i is high, outputs are forced: PC_write_o=0, IFID_write_o=0, IDEX_write_o=0, IDEX_bubble_o=1, EXMEM_bubble_o=1, IFID_flush_o=0, mul_done_o=0.
  - Reset during S_MUL abandons the MUL with no done pulse.
- **Default outputs** (no hazard): all write enables 1, all bubbles and flush 0, mul_done_o=0.
- **mul_stall** = (S_RUN && EX_MulStart_i) || (S_MUL && cnt!=0). When mul_stall=1:
  - PC_write_o=0, IFID_write_o=0, IDEX_write_o=0 (hold).
  - EXMEM_bubble_o=1.
  - Load-use and flush are suppressed.
- **MUL transitions.**
  - S_RUN with EX_MulStart_i: state<=S_MUL, cnt<=MUL_LAT-2.
  - S_MUL with cnt!=0: cnt<=cnt-1.
  - S_MUL with cnt==0: mul_done_o=1, no stall, state<=S_RUN.
  - Net effect: exactly MUL_LAT-1 stall cycles; mul_done_o is asserted in cycle MUL_LAT counting the start cycle as 1.
  - EX_MulStart_i while in S_MUL is ignored.
- **load_use** = EX_MemRead_i && EX_RTaddr_i!=0 && (EX_RTaddr_i==ID_RSaddr_i || (ID_UsesRT_i && EX_RTaddr_i==ID_RTaddr_i)).
  - Effective only when mul_stall=0.
  - Outputs: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; IDEX_write_o stays 1.
  - Lasts exactly 1 cycle, because the load leaves EX.
- **Flush.** IFID_flush_o = ID_BranchTaken_i && !mul_stall && !load_use.
  - A branch coincident with a stall gets no flush; it is re-evaluated when ID retries.
- **Priority:** reset > mul_stall > load_use > flush.
- **Counters:**
  - stall_cycles_o increments on every cycle with mul_stall||load_use.
  - flush_cycles_o increments on every cycle with IFID_flush_o.
  - Both saturate at all-ones and never wrap.
  - Both are registered, so the value is visible the cycle after the event.
- **Combinational paths:** all control outputs are combinational from state/cnt and the inputs (same-cycle response); only state, cnt and the counters are registers.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - State enum {S_RUN, S_MUL}.
  - Default MUL_LAT constant.
  - Register-address width constant (5).
- One sub-module, load_use_detect: the purely combinational load_use compare. The FSM, counters and output muxing stay in the top.

Test Plan:
- **Reset:** rst_i=1 for 2 cycles with EX_MulStart_i=1 → enables 0, bubbles 1, flush 0; after release state=S_RUN, counters 0.
- **Load-use:** EX_MemRead_i=1, EX_RTaddr_i=8, ID_RSaddr_i=8 → exactly 1 cycle of PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; stall_cycles_o=1 next cycle.
  - Repeat with EX_RTaddr_i=0 → no stall.
  - Repeat with rt match and ID_UsesRT_i=0 → no stall.
- **MUL, MUL_LAT=4:** EX_MulStart_i pulse at T0 → stall in T0..T2, mul_done_o=1 at T3, normal at T4; stall_cycles_o=3.
- **MUL + coincident events:** MUL start with load_use and ID_BranchTaken_i=1 in T0 → only the MUL stall outputs, IFID_flush_o=0, IDEX_bubble_o=0; a second EX_MulStart_i at T1 is ignored.
- **Branch:** ID_BranchTaken_i=1 with no hazards → IFID_flush_o=1 that cycle, flush_cycles_o +1.
  - Same with load_use active → no flush.
- **Mid-MUL reset and saturation:** rst_i at T1 of a MUL → S_RUN, no mul_done_o.
  - Separately, CNT_W=4 with 20 stall cycles → stall_cycles_o holds 15.
